uart_tx_ctrl: RTL

Transmit-side frame controller for the UART. It buffers bytes written by the register interface in a small FIFO and serializes each byte onto `uart_txd` as start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits. Every bit boundary is paced by the one-cycle `brg_tx_shift` tick from the baud rate generator, so all bits, including the first start bit, last exactly one tick period. It sits between the APB register block and the `uart_txd` pad.

---
 rtl/uart_tx_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: FIFO-buffered UART transmit framer paced by the baud-rate bit tick
module uart_tx_ctrl #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       pclk,
   input  logic       prst,
   input  logic       tx_en,
   input  logic       par_en,
   input  logic       par_odd,
   input  logic       stop2,
   input  logic       brg_tx_shift,
   input  logic       tx_wr,
   input  logic [7:0] tx_wdata,
   input  logic       tx_ovf_clr,
   output logic       uart_txd,
   output logic       tx_full,
   output logic       tx_empty,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_ovf
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

   state_t      state, state_nxt;
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wptr, rptr;
   logic [7:0]  shift, shift_nxt, head;
   logic [2:0]  bidx;
   logic        par_bit, push, pop, done_nxt, txd_nxt;

   assign tx_empty = wptr == rptr;
   assign tx_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign tx_busy  = state != IDLE;
   assign push     = tx_wr && !tx_full;
   assign head     = mem[rptr[AW-1:0]];

   // FIFO storage, written only when the push is accepted
   always_ff @(posedge pclk)
      if (push) mem[wptr[AW-1:0]] <= tx_wdata;

   // FIFO pointers; the extra MSB tells full from empty
   always_ff @(posedge pclk)
      if (prst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
      end

   // Sticky overflow flag; a dropped write beats a simultaneous clear
   always_ff @(posedge pclk)
      if (prst) tx_ovf <= 1'b0;
      else if (tx_wr && tx_full) tx_ovf <= 1'b1;
      else if (tx_ovf_clr) tx_ovf <= 1'b0;

   // Next-state, pop and next line value; frame end may chain straight into START
   always_comb begin
      state_nxt = state;
      shift_nxt = shift;
      pop       = 1'b0;
      done_nxt  = 1'b0;
      if (!tx_en) state_nxt = IDLE;
      else if (brg_tx_shift)
         case (state)
            IDLE:   if (!tx_empty) begin
                       pop       = 1'b1;
                       state_nxt = START;
                    end
            START:  state_nxt = DATA;
            DATA:   begin
                       shift_nxt = shift >> 1;
                       if (bidx == 3'd7) state_nxt = par_en ? PARITY : STOP1;
                    end
            PARITY: state_nxt = STOP1;
            STOP1:  if (stop2) state_nxt = STOP2;
                    else done_nxt = 1'b1;
            STOP2:  done_nxt = 1'b1;
            default: state_nxt = IDLE;
         endcase
      if (done_nxt) begin
         pop       = !tx_empty;
         state_nxt = tx_empty ? IDLE : START;
      end
      if (pop) shift_nxt = head;
      txd_nxt = state_nxt == START  ? 1'b0 :
                state_nxt == DATA   ? shift_nxt[0] :
                state_nxt == PARITY ? par_bit : 1'b1;
   end

   // Frame state, registered line, done pulse, shifter, bit index and parity
   always_ff @(posedge pclk)
      if (prst) begin
         state    <= IDLE;
         uart_txd <= 1'b1;
         tx_done  <= 1'b0;
         shift    <= '0;
         bidx     <= '0;
         par_bit  <= 1'b0;
      end else begin
         state    <= state_nxt;
         uart_txd <= txd_nxt;
         tx_done  <= done_nxt;
         shift    <= shift_nxt;
         bidx     <= state == DATA ? bidx + {2'b00, brg_tx_shift} : 3'd0;
         if (pop) par_bit <= ^head ^ par_odd;
      end
endmodule
